// File: rtl/ip_codma_bus_arbiter.sv
// ip_codma_bus_arbiter
// Round-robin arbiter that lets one of NREQ DMA requesters own a single
// memory bus for one burst at a time. It latches the winner's command,
// issues it on the bus, counts beats, and reports done/err to the owner.
// It aborts on CPU stop or when the bus makes no progress for TIMEOUT cycles.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   stop_i                  CPU abort request
//   req_*_i                 per-requester request, direction, address, beats-1,
//                           write data and write-data valid
//   gnt_o, done_o, err_o    one-hot owner, completion pulse, error pulse
//   beat_o, rdata_o         per-beat strobe and read data to the owner
//   bus_*_o / bus_*_i       memory bus request, write data and responses
module ip_codma_bus_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  stop_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       req_write_i,
  input  logic [NREQ-1:0][31:0] req_addr_i,
  input  logic [NREQ-1:0][2:0]  req_beats_i,
  input  logic [NREQ-1:0][63:0] req_wdata_i,
  input  logic [NREQ-1:0]       req_wvalid_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  beat_o,
  output logic [63:0]           rdata_o,
  output logic [NREQ-1:0]       done_o,
  output logic [NREQ-1:0]       err_o,
  output logic                  bus_read_o,
  output logic                  bus_write_o,
  output logic [31:0]           bus_addr_o,
  output logic [2:0]            bus_beats_o,
  output logic [63:0]           bus_wdata_o,
  output logic                  bus_wvalid_o,
  input  logic                  bus_grant_i,
  input  logic                  bus_rvalid_i,
  input  logic                  bus_wready_i,
  input  logic [63:0]           bus_rdata_i
);

  localparam int OW = (NREQ > 2) ? 2 : 1;
  localparam int PW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, ASK = 2'd1, XFER = 2'd2, DONE = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic            dir_q, dir_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      beats_q, beats_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [PW-1:0]   prog_q, prog_d;
  logic            err_q, err_d;

  logic [OW-1:0]   pick;
  logic [OW-1:0]   cand;
  logic            found;
  logic [NREQ-1:0] owner_oh;
  logic            beat;
  logic            stall_out;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      dir_q   <= 1'b0;
      addr_q  <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      prog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      prog_q  <= prog_d;
      err_q   <= err_d;
    end
  end

  // Round-robin search starting just after the previous owner
  always_comb begin
    pick  = owner_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = OW'((int'(last_q) + i) % NREQ);
      if (!found && req_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // No-progress limit reached this cycle (only meaningful in ASK/XFER)
  assign stall_out = (prog_q == PW'(TIMEOUT - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    prog_d  = prog_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (|req_i && !stop_i) begin
          state_d = ASK;
          owner_d = pick;
          dir_d   = req_write_i[pick];
          addr_d  = req_addr_i[pick];
          beats_d = req_beats_i[pick];
          prog_d  = '0;
          err_d   = 1'b0;
        end
      end
      ASK: begin
        if (stop_i || (!bus_grant_i && stall_out)) begin
          state_d = DONE;
          err_d   = 1'b1;
          last_d  = owner_q;
        end else if (bus_grant_i) begin
          state_d = XFER;
          cnt_d   = '0;
          prog_d  = '0;
        end else begin
          prog_d  = prog_q + 1'b1;
        end
      end
      XFER: begin
        if (beat) begin
          cnt_d  = cnt_q + 3'd1;
          prog_d = '0;
        end else begin
          prog_d = prog_q + 1'b1;
        end
        // A final beat coinciding with stop still counts, but the burst ends in error.
        if (stop_i || (beat && cnt_q == beats_q) || (!beat && stall_out)) begin
          state_d = DONE;
          err_d   = stop_i | (!beat & stall_out);
          last_d  = owner_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

  // Output logic
  always_comb begin
    gnt_o        = '0;
    done_o       = '0;
    err_o        = '0;
    bus_read_o   = 1'b0;
    bus_write_o  = 1'b0;
    bus_addr_o   = '0;
    bus_beats_o  = '0;
    bus_wdata_o  = '0;
    bus_wvalid_o = 1'b0;
    beat         = 1'b0;
    rdata_o      = '0;
    case (state_q)
      ASK: begin
        gnt_o       = owner_oh;
        bus_read_o  = !dir_q && !stop_i;
        bus_write_o = dir_q && !stop_i;
        bus_addr_o  = addr_q;
        bus_beats_o = beats_q;
      end
      XFER: begin
        gnt_o       = owner_oh;
        bus_addr_o  = addr_q;
        bus_beats_o = beats_q;
        if (dir_q) begin
          bus_wdata_o  = req_wdata_i[owner_q];
          bus_wvalid_o = req_wvalid_i[owner_q] && !stop_i;
          beat         = bus_wvalid_o && bus_wready_i;
        end else begin
          beat    = bus_rvalid_i;
          rdata_o = bus_rvalid_i ? bus_rdata_i : '0;
        end
      end
      DONE: begin
        gnt_o  = owner_oh;
        done_o = owner_oh;
        err_o  = err_q ? owner_oh : '0;
      end
      default: begin
      end
    endcase
  end

  assign beat_o = beat;

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
module tb_ip_codma_bus_arbiter;

  logic             clk = 1'b0;
  logic             rst, stop;
  logic [2:0]       req, req_write, req_wvalid;
  logic [2:0][31:0] req_addr;
  logic [2:0][2:0]  req_beats;
  logic [2:0][63:0] req_wdata;
  logic [2:0]       gnt, done, err;
  logic             beat, bus_read, bus_write, bus_wvalid;
  logic [63:0]      rdata, bus_wdata, bus_rdata;
  logic [31:0]      bus_addr;
  logic [2:0]       bus_beats;
  logic             bus_grant, bus_rvalid, bus_wready;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ip_codma_bus_arbiter #(.NREQ(3), .TIMEOUT(256)) dut (
    .clk_i(clk), .reset_i(rst), .stop_i(stop),
    .req_i(req), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_beats_i(req_beats), .req_wdata_i(req_wdata), .req_wvalid_i(req_wvalid),
    .gnt_o(gnt), .beat_o(beat), .rdata_o(rdata), .done_o(done), .err_o(err),
    .bus_read_o(bus_read), .bus_write_o(bus_write), .bus_addr_o(bus_addr),
    .bus_beats_o(bus_beats), .bus_wdata_o(bus_wdata), .bus_wvalid_o(bus_wvalid),
    .bus_grant_i(bus_grant), .bus_rvalid_i(bus_rvalid), .bus_wready_i(bus_wready),
    .bus_rdata_i(bus_rdata)
  );

  localparam logic        O = 1'b0, I = 1'b1;
  localparam logic [2:0]  N = 3'b000, R0 = 3'b001, R1 = 3'b010, R2 = 3'b100;
  localparam logic [2:0]  B0 = 3'd0, B1 = 3'd1, B3 = 3'd3;
  localparam logic [31:0] AZ = 32'h0, A0 = 32'h1000, A1 = 32'h2000, A2 = 32'h3000;
  localparam logic [63:0] Z = 64'h0, W1 = 64'hA5A5_0000_0000_0001;

  typedef struct {
    logic        rst, stop, grant, rvalid, wready;
    logic [2:0]  req, wv;
    logic [63:0] brd;
    logic [2:0]  e_gnt, e_done, e_err, e_beats;
    logic        e_beat, e_rd, e_wr, e_wv;
    logic [63:0] e_rdata, e_wdata;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vec(
    input logic rst_v, input logic [2:0] req_v, input logic stop_v, input logic grant_v,
    input logic rvalid_v, input logic [63:0] brd_v, input logic wready_v, input logic [2:0] wv_v,
    input logic [2:0] gnt_e, input logic beat_e, input logic [63:0] rdata_e,
    input logic [2:0] done_e, input logic [2:0] err_e, input logic rd_e, input logic wr_e,
    input logic wvo_e, input logic [31:0] addr_e, input logic [2:0] beats_e, input logic [63:0] wdata_e);
    vec_t v;
    v.rst = rst_v; v.req = req_v; v.stop = stop_v; v.grant = grant_v; v.rvalid = rvalid_v;
    v.brd = brd_v; v.wready = wready_v; v.wv = wv_v;
    v.e_gnt = gnt_e; v.e_beat = beat_e; v.e_rdata = rdata_e; v.e_done = done_e; v.e_err = err_e;
    v.e_rd = rd_e; v.e_wr = wr_e; v.e_wv = wvo_e; v.e_addr = addr_e; v.e_beats = beats_e;
    v.e_wdata = wdata_e;
    return v;
  endfunction

  // Vector whose expected outputs are all zero
  function automatic vec_t zv(input logic rst_v, input logic [2:0] req_v, input logic stop_v);
    return vec(rst_v, req_v, stop_v, O, O, Z, O, N, N, O, Z, N, N, O, O, O, AZ, B0, Z);
  endfunction

  function automatic logic [175:0] actual();
    return {gnt, beat, rdata, done, err, bus_read, bus_write, bus_wvalid, bus_addr, bus_beats, bus_wdata};
  endfunction

  function automatic logic [175:0] expect_of(input vec_t v);
    return {v.e_gnt, v.e_beat, v.e_rdata, v.e_done, v.e_err, v.e_rd, v.e_wr, v.e_wv,
            v.e_addr, v.e_beats, v.e_wdata};
  endfunction

  task automatic check(input string name, input logic [175:0] act, input logic [175:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    stop = 1'b0; req = '0; bus_grant = 1'b0; bus_rvalid = 1'b0;
    bus_wready = 1'b0; req_wvalid = '0; bus_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [2:0] order[4];
  int nd, bad, cyc, n;

  initial begin
    rst = 1'b1;
    idle_inputs();
    req_write    = 3'b010;
    req_addr[0]  = A0;  req_addr[1]  = A1;  req_addr[2]  = A2;
    req_beats[0] = B3;  req_beats[1] = B1;  req_beats[2] = B0;
    req_wdata[0] = 64'h0BAD_0000_0000_0000;
    req_wdata[1] = W1;
    req_wdata[2] = 64'h0BAD_0000_0000_0002;
    do_reset();

    // reset state
    tbl.push_back(zv(O, N, O));
    // 4-beat read by requester 0
    tbl.push_back(zv(O, R0, O));
    tbl.push_back(vec(O, R0, O, O, O, Z, O, N, R0, O, Z, N, N, I, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, O, I, O, Z, O, N, R0, O, Z, N, N, I, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, O, O, I, 64'h11, O, N, R0, I, 64'h11, N, N, O, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, O, O, O, 64'hEE, O, N, R0, O, Z, N, N, O, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, O, O, I, 64'h22, O, N, R0, I, 64'h22, N, N, O, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, O, O, I, 64'h33, O, N, R0, I, 64'h33, N, N, O, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, O, O, I, 64'h44, O, N, R0, I, 64'h44, N, N, O, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, O, O, O, Z, O, N, R0, O, Z, R0, N, O, O, O, AZ, B0, Z));
    tbl.push_back(zv(O, N, O));
    // 2-beat write by requester 1, wready toggling
    tbl.push_back(zv(O, R1, O));
    tbl.push_back(vec(O, R1, O, I, O, Z, O, R1, R1, O, Z, N, N, O, I, O, A1, B1, Z));
    tbl.push_back(vec(O, R1, O, O, I, 64'h77, O, R1, R1, O, Z, N, N, O, O, I, A1, B1, W1));
    tbl.push_back(vec(O, R1, O, O, O, Z, I, R1, R1, I, Z, N, N, O, O, I, A1, B1, W1));
    tbl.push_back(vec(O, R1, O, O, O, Z, O, R1, R1, O, Z, N, N, O, O, I, A1, B1, W1));
    tbl.push_back(vec(O, R1, O, O, O, Z, I, R1, R1, I, Z, N, N, O, O, I, A1, B1, W1));
    tbl.push_back(vec(O, R1, O, O, O, Z, O, N, R1, O, Z, R1, N, O, O, O, AZ, B0, Z));
    tbl.push_back(zv(O, N, O));
    // stop during read after beat 1 of 4
    tbl.push_back(zv(O, R0, O));
    tbl.push_back(vec(O, R0, O, I, O, Z, O, N, R0, O, Z, N, N, I, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, O, O, I, 64'h55, O, N, R0, I, 64'h55, N, N, O, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, I, O, O, Z, O, N, R0, O, Z, N, N, O, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, O, O, O, Z, O, N, R0, O, Z, R0, R0, O, O, O, AZ, B0, Z));
    tbl.push_back(zv(O, N, O));
    // stop during write: wvalid drops in the same cycle
    tbl.push_back(zv(O, R1, O));
    tbl.push_back(vec(O, R1, O, I, O, Z, O, R1, R1, O, Z, N, N, O, I, O, A1, B1, Z));
    tbl.push_back(vec(O, R1, O, O, O, Z, I, R1, R1, I, Z, N, N, O, O, I, A1, B1, W1));
    tbl.push_back(vec(O, R1, I, O, O, Z, I, R1, R1, O, Z, N, N, O, O, O, A1, B1, W1));
    tbl.push_back(vec(O, R1, O, O, O, Z, O, N, R1, O, Z, R1, R1, O, O, O, AZ, B0, Z));
    tbl.push_back(zv(O, N, O));
    // stop in ASK: request drops the same cycle, grant ignored
    tbl.push_back(zv(O, R2, O));
    tbl.push_back(vec(O, R2, O, O, O, Z, O, N, R2, O, Z, N, N, I, O, O, A2, B0, Z));
    tbl.push_back(vec(O, R2, I, I, O, Z, O, N, R2, O, Z, N, N, O, O, O, A2, B0, Z));
    tbl.push_back(vec(O, R2, O, O, O, Z, O, N, R2, O, Z, R2, R2, O, O, O, AZ, B0, Z));
    tbl.push_back(zv(O, N, O));
    // stop together with the final beat
    tbl.push_back(zv(O, R2, O));
    tbl.push_back(vec(O, R2, O, I, O, Z, O, N, R2, O, Z, N, N, I, O, O, A2, B0, Z));
    tbl.push_back(vec(O, R2, I, O, I, 64'h66, O, N, R2, I, 64'h66, N, N, O, O, O, A2, B0, Z));
    tbl.push_back(vec(O, R2, O, O, O, Z, O, N, R2, O, Z, R2, R2, O, O, O, AZ, B0, Z));
    tbl.push_back(zv(O, N, O));
    // reset mid-XFER: no done, rvalid ignored afterwards
    tbl.push_back(zv(O, R0, O));
    tbl.push_back(vec(O, R0, O, I, O, Z, O, N, R0, O, Z, N, N, I, O, O, A0, B3, Z));
    tbl.push_back(vec(O, R0, O, O, I, 64'h77, O, N, R0, I, 64'h77, N, N, O, O, O, A0, B3, Z));
    tbl.push_back(vec(I, R0, O, O, I, 64'h88, O, N, R0, I, 64'h88, N, N, O, O, O, A0, B3, Z));
    tbl.push_back(vec(O, N, O, O, I, 64'h99, O, N, N, O, Z, N, N, O, O, O, AZ, B0, Z));
    tbl.push_back(zv(O, N, O));
    // stop in IDLE blocks new grants
    tbl.push_back(zv(O, R0, I));
    tbl.push_back(zv(O, R0, I));
    tbl.push_back(zv(O, N, O));

    foreach (tbl[k]) begin
      @(negedge clk);
      rst        = tbl[k].rst;
      req        = tbl[k].req;
      stop       = tbl[k].stop;
      bus_grant  = tbl[k].grant;
      bus_rvalid = tbl[k].rvalid;
      bus_rdata  = tbl[k].brd;
      bus_wready = tbl[k].wready;
      req_wvalid = tbl[k].wv;
      #1;
      check($sformatf("vec%0d", k), actual(), expect_of(tbl[k]));
    end

    // Round robin with all requesters held high
    do_reset();
    req = 3'b111; bus_grant = 1'b1; bus_rvalid = 1'b1; bus_wready = 1'b1;
    req_wvalid = 3'b111; bus_rdata = 64'h1234;
    nd = 0; bad = 0; cyc = 0;
    while (nd < 4 && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
      if (gnt != 3'b000 && !$onehot(gnt)) bad++;
      if (done != 3'b000) begin
        order[nd] = done;
        nd++;
      end
    end
    check("rr_count", 176'(nd), 176'(4));
    check("rr_onehot", 176'(bad), 176'(0));
    check("rr_order0", 176'(order[0]), 176'(R0));
    check("rr_order1", 176'(order[1]), 176'(R1));
    check("rr_order2", 176'(order[2]), 176'(R2));
    check("rr_order3", 176'(order[3]), 176'(R0));

    // Timeout: bus never grants
    do_reset();
    req = R2;
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (gnt == 3'b000 && cyc < 10);
    check("to_ask", 176'(gnt), 176'(R2));
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (done == 3'b000 && n < 300);
    check("to_cycles", 176'(n), 176'(256));
    check("to_done_err", 176'({done, err}), 176'({R2, R2}));
    req = N;
    @(negedge clk); #1;
    check("to_idle", 176'({gnt, done, err, bus_read}), 176'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
